// File: rtl/seq_gen_pkg.sv
// Shared protocol definitions for the 8-state sequence generator/recognizer pair:
// symbol codes, generator state encoding and the symbol mapping helper.
package seq_gen_pkg;

   localparam logic [2:0] SYM_IDLE  = 3'd0;
   localparam logic [2:0] SYM_S1_A  = 3'd1;
   localparam logic [2:0] SYM_S1_B  = 3'd2;
   localparam logic [2:0] SYM_S1_C  = 3'd3;
   localparam logic [2:0] SYM_S2_A  = 3'd4;
   localparam logic [2:0] SYM_S2_B  = 3'd5;
   localparam logic [2:0] SYM_S2_C  = 3'd6;
   localparam logic [2:0] SYM_ERROR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_A    = 2'd1,
      ST_B    = 2'd2,
      ST_C    = 2'd3
   } gen_state_e;

   typedef enum logic [1:0] {
      PH_A = 2'd0,
      PH_B = 2'd1,
      PH_C = 2'd2
   } seq_phase_e;

   // typ: 0 = S1, 1 = S2; corrupt replaces only the B symbol
   function automatic logic [2:0] seq_symbol(input logic typ, input seq_phase_e ph,
                                             input logic corrupt);
      logic [2:0] base;
      logic [2:0] sym;
      base = typ ? SYM_S2_A : SYM_S1_A;
      case (ph)
         PH_A:    sym = base;
         PH_B:    sym = corrupt ? SYM_ERROR : base + 3'd1;
         PH_C:    sym = base + 3'd2;
         default: sym = SYM_IDLE;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/seq_generator_if.sv
// Request/status bundle of the sequence generator; the slave side is the generator.
interface seq_generator_if #(
   parameter int IO_SIZE_G = 3,
   parameter int COUNT_W_G = 8
) ();
   logic                 start_i;
   logic                 sel_i;
   logic                 alt_i;
   logic                 inject_err_i;
   logic [COUNT_W_G-1:0] burst_len_i;
   logic                 abort_i;
   logic                 ready_o;
   logic [IO_SIZE_G-1:0] data_o;
   logic                 done_o;
   logic                 aborted_o;
   logic [COUNT_W_G-1:0] sent_cnt_o;

   modport master (
      output start_i, sel_i, alt_i, inject_err_i, burst_len_i, abort_i,
      input  ready_o, data_o, done_o, aborted_o, sent_cnt_o
   );

   modport slave (
      input  start_i, sel_i, alt_i, inject_err_i, burst_len_i, abort_i,
      output ready_o, data_o, done_o, aborted_o, sent_cnt_o
   );
endinterface

// File: rtl/seq_gen_next_state.sv
// Purely combinational next-state and next-symbol logic of the generator,
// isolated so it can be triplicated without touching the state registers.
module seq_gen_next_state
   import seq_gen_pkg::*;
#(
   parameter int COUNT_W_G = 8
) (
   input  gen_state_e           state_i,
   input  logic                 type_i,
   input  logic                 alt_i,
   input  logic                 inject_i,
   input  logic [COUNT_W_G-1:0] rem_i,
   input  logic [COUNT_W_G-1:0] sent_cnt_i,
   input  logic                 ready_i,
   input  logic                 start_req_i,
   input  logic                 sel_req_i,
   input  logic                 alt_req_i,
   input  logic                 inject_req_i,
   input  logic [COUNT_W_G-1:0] burst_len_i,
   input  logic                 abort_i,
   output gen_state_e           state_o,
   output logic                 type_o,
   output logic                 alt_o,
   output logic                 inject_o,
   output logic [COUNT_W_G-1:0] rem_o,
   output logic [COUNT_W_G-1:0] sent_cnt_o,
   output logic [2:0]           sym_o,
   output logic                 done_o,
   output logic                 aborted_o,
   output logic                 ready_o
);

   // next-state, next-symbol and status decode
   always_comb begin
      state_o    = state_i;
      type_o     = type_i;
      alt_o      = alt_i;
      inject_o   = inject_i;
      rem_o      = rem_i;
      sent_cnt_o = sent_cnt_i;
      sym_o      = SYM_IDLE;
      done_o     = 1'b0;
      aborted_o  = 1'b0;

      case (state_i)
         ST_IDLE: begin
            if (start_req_i && ready_i) begin
               sent_cnt_o = '0;
               if (burst_len_i != '0) begin
                  state_o  = ST_A;
                  type_o   = sel_req_i;
                  alt_o    = alt_req_i;
                  inject_o = inject_req_i;
                  rem_o    = burst_len_i;
                  sym_o    = seq_symbol(sel_req_i, PH_A, 1'b0);
               end else begin
                  done_o = 1'b1;
               end
            end else begin
               state_o = ST_IDLE;
            end
         end
         ST_A: begin
            if (abort_i) begin
               state_o   = ST_IDLE;
               done_o    = 1'b1;
               aborted_o = 1'b1;
            end else begin
               state_o = ST_B;
               sym_o   = seq_symbol(type_i, PH_B, inject_i);
            end
         end
         ST_B: begin
            // injection only ever hits the first B of a burst
            inject_o = 1'b0;
            if (abort_i) begin
               state_o   = ST_IDLE;
               done_o    = 1'b1;
               aborted_o = 1'b1;
            end else begin
               state_o = ST_C;
               sym_o   = seq_symbol(type_i, PH_C, 1'b0);
            end
         end
         ST_C: begin
            // the sequence is complete even if abort arrives in this cycle
            sent_cnt_o = sent_cnt_i + {{(COUNT_W_G-1){1'b0}}, 1'b1};
            rem_o      = rem_i - {{(COUNT_W_G-1){1'b0}}, 1'b1};
            if (abort_i) begin
               state_o   = ST_IDLE;
               done_o    = 1'b1;
               aborted_o = 1'b1;
            end else if (rem_i > {{(COUNT_W_G-1){1'b0}}, 1'b1}) begin
               state_o = ST_A;
               type_o  = alt_i ? ~type_i : type_i;
               sym_o   = seq_symbol(alt_i ? ~type_i : type_i, PH_A, 1'b0);
            end else begin
               state_o = ST_IDLE;
               done_o  = 1'b1;
            end
         end
         default: begin
            state_o = ST_IDLE;
         end
      endcase

      ready_o = (state_o == ST_IDLE) && !done_o;
   end

endmodule

// File: rtl/seq_generator.sv
// Burst generator of S1/S2 three-symbol sequences driving the recognizer symbol bus.
// All outputs come straight from flops; decode lives in seq_gen_next_state.
module seq_generator
   import seq_gen_pkg::*;
#(
   parameter int IO_SIZE_G = 3,
   parameter int COUNT_W_G = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   seq_generator_if.slave bus
);

   gen_state_e           state_q,    state_d;
   logic                 type_q,     type_d;
   logic                 alt_q,      alt_d;
   logic                 inject_q,   inject_d;
   logic [COUNT_W_G-1:0] rem_q,      rem_d;
   logic [COUNT_W_G-1:0] sent_cnt_q, sent_cnt_d;
   logic [IO_SIZE_G-1:0] data_q,     data_d;
   logic                 done_q,     done_d;
   logic                 aborted_q,  aborted_d;
   logic                 ready_q,    ready_d;
   logic [2:0]           sym_s;

   seq_gen_next_state #(
      .COUNT_W_G (COUNT_W_G)
   ) u_next (
      .state_i      (state_q),
      .type_i       (type_q),
      .alt_i        (alt_q),
      .inject_i     (inject_q),
      .rem_i        (rem_q),
      .sent_cnt_i   (sent_cnt_q),
      .ready_i      (ready_q),
      .start_req_i  (bus.start_i),
      .sel_req_i    (bus.sel_i),
      .alt_req_i    (bus.alt_i),
      .inject_req_i (bus.inject_err_i),
      .burst_len_i  (bus.burst_len_i),
      .abort_i      (bus.abort_i),
      .state_o      (state_d),
      .type_o       (type_d),
      .alt_o        (alt_d),
      .inject_o     (inject_d),
      .rem_o        (rem_d),
      .sent_cnt_o   (sent_cnt_d),
      .sym_o        (sym_s),
      .done_o       (done_d),
      .aborted_o    (aborted_d),
      .ready_o      (ready_d)
   );

   // symbol width is fixed by the protocol; adapt to the bus width
   always_comb begin
      data_d = IO_SIZE_G'(sym_s);
   end

   // state and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         type_q     <= 1'b0;
         alt_q      <= 1'b0;
         inject_q   <= 1'b0;
         rem_q      <= '0;
         sent_cnt_q <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         alt_q      <= alt_d;
         inject_q   <= inject_d;
         rem_q      <= rem_d;
         sent_cnt_q <= sent_cnt_d;
         data_q     <= data_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.ready_o    = ready_q;
   assign bus.data_o     = data_q;
   assign bus.done_o     = done_q;
   assign bus.aborted_o  = aborted_q;
   assign bus.sent_cnt_o = sent_cnt_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: fixed bursts with hand-computed symbol streams.
module tb_seq_generator;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   seq_generator_if #(.IO_SIZE_G(3), .COUNT_W_G(8)) ifc ();

   seq_generator #(.IO_SIZE_G(3), .COUNT_W_G(8)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (ifc)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] EXP_ONE [4]  = '{3'd1, 3'd2, 3'd3, 3'd0};
   localparam logic [2:0] EXP_ALT [10] = '{3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3,
                                           3'd4, 3'd5, 3'd6, 3'd0};
   localparam logic [2:0] EXP_INJ [7]  = '{3'd1, 3'd7, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0};
   localparam logic [2:0] EXP_S2 [4]   = '{3'd4, 3'd5, 3'd6, 3'd0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic sel, input logic alt, input logic inj,
                           input logic [7:0] len);
      ifc.start_i      = 1'b1;
      ifc.sel_i        = sel;
      ifc.alt_i        = alt;
      ifc.inject_err_i = inj;
      ifc.burst_len_i  = len;
      tick();
      ifc.start_i      = 1'b0;
      ifc.sel_i        = 1'b0;
      ifc.alt_i        = 1'b0;
      ifc.inject_err_i = 1'b0;
      ifc.burst_len_i  = 8'd0;
   endtask

   task automatic chk_idle_after(input string tag);
      tick();
      chk({tag, "_done_clr"}, 32'(ifc.done_o), 32'd0);
      chk({tag, "_ready"}, 32'(ifc.ready_o), 32'd1);
      chk({tag, "_data"}, 32'(ifc.data_o), 32'd0);
   endtask

   initial begin
      rst_n            = 1'b0;
      ifc.start_i      = 1'b0;
      ifc.sel_i        = 1'b0;
      ifc.alt_i        = 1'b0;
      ifc.inject_err_i = 1'b0;
      ifc.burst_len_i  = 8'd0;
      ifc.abort_i      = 1'b0;
      tick();
      tick();
      chk("rst_data", 32'(ifc.data_o), 32'd0);
      chk("rst_ready", 32'(ifc.ready_o), 32'd1);
      chk("rst_done", 32'(ifc.done_o), 32'd0);
      chk("rst_abt", 32'(ifc.aborted_o), 32'd0);
      chk("rst_cnt", 32'(ifc.sent_cnt_o), 32'd0);
      rst_n = 1'b1;
      tick();

      // abort while idle does nothing
      ifc.abort_i = 1'b1;
      tick();
      ifc.abort_i = 1'b0;
      chk("idle_abort_done", 32'(ifc.done_o), 32'd0);
      chk("idle_abort_ready", 32'(ifc.ready_o), 32'd1);

      // single S1 sequence
      do_start(1'b0, 1'b0, 1'b0, 8'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         chk($sformatf("one_data%0d", i), 32'(ifc.data_o), 32'(EXP_ONE[i]));
         chk($sformatf("one_done%0d", i), 32'(ifc.done_o), (i == 3) ? 32'd1 : 32'd0);
         chk($sformatf("one_ready%0d", i), 32'(ifc.ready_o), 32'd0);
      end
      chk("one_cnt", 32'(ifc.sent_cnt_o), 32'd1);
      chk("one_abt", 32'(ifc.aborted_o), 32'd0);
      chk_idle_after("one");

      // alternating burst starting with S2
      do_start(1'b1, 1'b1, 1'b0, 8'd3);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         chk($sformatf("alt_data%0d", i), 32'(ifc.data_o), 32'(EXP_ALT[i]));
         chk($sformatf("alt_done%0d", i), 32'(ifc.done_o), (i == 9) ? 32'd1 : 32'd0);
      end
      chk("alt_cnt", 32'(ifc.sent_cnt_o), 32'd3);
      chk("alt_abt", 32'(ifc.aborted_o), 32'd0);
      chk_idle_after("alt");

      // error injection on the first B only
      do_start(1'b0, 1'b0, 1'b1, 8'd2);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick();
         chk($sformatf("inj_data%0d", i), 32'(ifc.data_o), 32'(EXP_INJ[i]));
         chk($sformatf("inj_done%0d", i), 32'(ifc.done_o), (i == 6) ? 32'd1 : 32'd0);
      end
      chk("inj_cnt", 32'(ifc.sent_cnt_o), 32'd2);
      chk_idle_after("inj");

      // zero-length burst
      do_start(1'b0, 1'b0, 1'b0, 8'd0);
      chk("zero_data", 32'(ifc.data_o), 32'd0);
      chk("zero_done", 32'(ifc.done_o), 32'd1);
      chk("zero_abt", 32'(ifc.aborted_o), 32'd0);
      chk("zero_cnt", 32'(ifc.sent_cnt_o), 32'd0);
      chk("zero_ready", 32'(ifc.ready_o), 32'd0);
      chk_idle_after("zero");

      // abort in the B phase of the second sequence
      do_start(1'b0, 1'b0, 1'b0, 8'd4);
      for (int i = 0; i < 4; i++) tick();
      chk("abB_pre", 32'(ifc.data_o), 32'd2);
      ifc.abort_i = 1'b1;
      tick();
      ifc.abort_i = 1'b0;
      chk("abB_data", 32'(ifc.data_o), 32'd0);
      chk("abB_done", 32'(ifc.done_o), 32'd1);
      chk("abB_abt", 32'(ifc.aborted_o), 32'd1);
      chk("abB_cnt", 32'(ifc.sent_cnt_o), 32'd1);
      // start while done is high must be dropped
      do_start(1'b1, 1'b0, 1'b0, 8'd2);
      chk("ign_data", 32'(ifc.data_o), 32'd0);
      chk("ign_done", 32'(ifc.done_o), 32'd0);
      chk("ign_ready", 32'(ifc.ready_o), 32'd1);
      chk("ign_cnt", 32'(ifc.sent_cnt_o), 32'd1);
      tick();
      chk("ign_data2", 32'(ifc.data_o), 32'd0);

      // abort coinciding with sequence completion still counts that sequence
      do_start(1'b0, 1'b0, 1'b0, 8'd2);
      tick();
      tick();
      chk("abC_pre", 32'(ifc.data_o), 32'd3);
      ifc.abort_i = 1'b1;
      tick();
      ifc.abort_i = 1'b0;
      chk("abC_data", 32'(ifc.data_o), 32'd0);
      chk("abC_done", 32'(ifc.done_o), 32'd1);
      chk("abC_abt", 32'(ifc.aborted_o), 32'd1);
      chk("abC_cnt", 32'(ifc.sent_cnt_o), 32'd1);
      chk_idle_after("abC");

      // asynchronous reset in the B phase
      do_start(1'b0, 1'b0, 1'b0, 8'd3);
      tick();
      chk("rstB_pre", 32'(ifc.data_o), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstB_data", 32'(ifc.data_o), 32'd0);
      chk("rstB_ready", 32'(ifc.ready_o), 32'd1);
      chk("rstB_done", 32'(ifc.done_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rstB_done2", 32'(ifc.done_o), 32'd0);
      chk("rstB_cnt", 32'(ifc.sent_cnt_o), 32'd0);

      // normal burst after the reset
      do_start(1'b1, 1'b0, 1'b0, 8'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         chk($sformatf("post_data%0d", i), 32'(ifc.data_o), 32'(EXP_S2[i]));
         chk($sformatf("post_done%0d", i), 32'(ifc.done_o), (i == 3) ? 32'd1 : 32'd0);
      end
      chk("post_cnt", 32'(ifc.sent_cnt_o), 32'd1);
      chk_idle_after("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
